convert_outputs: RTL and testbench
==================================

Name: convert_outputs

Overview:
- Output-side counterpart of the FP adder's input widening stage.
- Narrows a double-format adder result back to single precision when the operation ran as a widened single, using IEEE rounding.
- Passes double results through unchanged.
- Two-stage pipeline with valid/ready handshake between the adder datapath and the result writeback.

Parameters:
- PIPE_DEPTH, 2, number of register stages; fixed at 2, other values unsupported.
- QNAN_SP, 32'h7FC00000, canonical single NaN pattern.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  result from adder valid.
- in_ready  out  1  block can accept.
- result_dp  in  64  adder result in double format.
- op_type  in  3  function opcode travelling with the result.
- P  in  2  result precision (00 double, 01 single).
- rm  in  2  rounding mode: 00 RNE, 01 RZ, 10 RU (+inf), 11 RD (-inf).
- out_valid  out  1  converted result valid.
- out_ready  in  1  downstream accepts.
- result  out  64  final result; single packed in [63:32], [31:0] zero.
- flag_of  out  1  overflow.
- flag_uf  out  1  underflow.
- flag_nx  out  1  inexact.

Behaviour:
- conv_SP = (op_type[2]&op_type[1]) ^ P[0]; computed and registered in stage 1.
- Reset (async): s1_valid=0, s2_valid=0; out_valid=0, result=0, all flags=0; in_ready=1 after reset deasserts.
- Handshake:
  - Transfer on valid&ready.
  - Stage 2 loads when empty or when out_ready=1; stage 1 loads when empty or advancing.
  - in_ready = ~s1_valid | (~s2_valid | out_ready).
  - Latency 2 cycles from accept to out_valid with no backpressure; throughput 1/cycle.
  - result and flags hold stable while out_valid=1 and out_ready=0.
- Stage 1 (decode, conv_SP=1):
  - Inputs: s=result_dp[63], e=[62:52], f=[51:0].
  - Rebiased exponent es = e - 896 (signed 12-bit); m = f[51:29]; G = f[28]; S = |f[27:0].
  - Classify: NaN (e=7FF, f≠0), Inf (e=7FF, f=0), zero (e=0, f=0), tiny (e≠7FF and es≤0, nonzero), normal.
- Stage 2 (round/pack):
  - Increment rules:
    - RNE: G&(S|m[0]).
    - RZ: 0.
    - RU: ~s&(G|S).
    - RD: s&(G|S).
  - {c,m'} = m + inc. If c=1, m'=0 and es+1.
  - Overflow: es≥255 after rounding, flag_of=1 and flag_nx=1.
    - Result is ±Inf for RNE, for RU when positive, and for RD when negative.
    - Otherwise result is ±7F7FFFFF (max finite, sign kept).
  - Normal result: {s, es[7:0], m'}; flag_nx = G|S.
  - Tiny result: flush to signed zero; flag_uf=1, flag_nx=1; rm ignored. This covers DP denormals and es=0 cases.
  - Zero: signed zero, no flags.
  - Inf: {s,8'hFF,23'h0}, no flags.
  - NaN: QNAN_SP, no flags.
- Pass-through (conv_SP=0): result=result_dp, flags 0, same 2-cycle latency.
- Simultaneous accept and drain on a full pipe: both stages advance in the same cycle with no bubble.
- Reset mid-operation: in-flight results are discarded and out_valid drops immediately (async).

Test Plan:
- P=01, op_type=000, rm=RNE, result_dp=3FF0000000000000 → result=3F80000000000000 two cycles later; flags 000.
- RNE tie cases:
  - 3FF0000010000000 → 3F80000000000000 (tie, even lsb kept), nx=1.
  - 3FF0000030000000 → 3F80000200000000, nx=1.
- Overflow with 47F0000000000000 (es=255):
  - RNE → 7F80000000000000, of=1, nx=1.
  - RZ → 7F7FFFFF00000000.
  - Sign bit set with RU → FF7FFFFF00000000.
- Underflow: 3800000000000000 (es=0) → 0000000000000000, uf=1, nx=1.
- Specials:
  - 7FF8000000000000 → 7FC0000000000000.
  - FFF0000000000000 → FF80000000000000.
  - P=00, op_type=000 → 64-bit pass-through unchanged.
- Backpressure: stream 4 results with out_ready=0 for 3 cycles.
  - Exactly 2 are accepted, then in_ready=0, and out_valid/result stay stable.
  - After out_ready=1, all 4 emerge in order with no drop or duplicate.
  - Assert reset with 2 in flight → out_valid=0 immediately; nothing emitted after release.

Source files
------------

// File: rtl/convert_outputs.sv
// convert_outputs: narrows a double-format FP adder result back to single
// precision when the operation ran as a widened single. Double results pass
// through unchanged. Two register stages with a valid/ready handshake:
// stage 1 decodes the double fields and stage 2 rounds and packs.
module convert_outputs #(
  parameter int          PIPE_DEPTH = 2,
  parameter logic [31:0] QNAN_SP    = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] result_dp,
  input  logic [2:0]  op_type,
  input  logic [1:0]  P,
  input  logic [1:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        flag_of,
  output logic        flag_uf,
  output logic        flag_nx
);

  // Bit 0 is the decode stage and bit 1 is the round/pack stage.
  logic [PIPE_DEPTH-1:0] valid_q;
  logic [PIPE_DEPTH-1:0] valid_d;
  logic                  advance2;
  logic                  load1;

  // Stage 1 decode results
  logic               conv_d;
  logic [10:0]        expField;
  logic [51:0]        fracField;
  logic signed [11:0] es_d;
  logic               nan_d;
  logic               inf_d;
  logic               zero_d;
  logic               tiny_d;

  logic               s1Conv_q;
  logic [63:0]        s1Dp_q;
  logic signed [11:0] s1Es_q;
  logic [22:0]        s1Man_q;
  logic               s1Guard_q;
  logic               s1Sticky_q;
  logic               s1Nan_q;
  logic               s1Inf_q;
  logic               s1Zero_q;
  logic               s1Tiny_q;
  logic [1:0]         s1Rm_q;

  // Stage 2 rounding and packing
  logic               sign;
  logic               inc;
  logic               carry;
  logic [22:0]        manRnd;
  logic signed [11:0] esRnd;
  logic               overflow;
  logic               toInf;
  logic [63:0]        result_d;
  logic               of_d;
  logic               uf_d;
  logic               nx_d;

  logic [63:0]        result_q;
  logic               of_q;
  logic               uf_q;
  logic               nx_q;

  // The opcode LSB and the upper precision bit do not affect conversion.
  logic               unusedInputs;
  assign unusedInputs = ^{op_type[0], P[1]};

  // Handshake: stage 2 moves when empty or drained; stage 1 moves when empty
  // or when stage 2 takes its contents, so a full pipe streams with no bubble.
  always_comb begin
    advance2   = ~valid_q[1] | out_ready;
    load1      = ~valid_q[0] | advance2;
    in_ready   = load1;
    valid_d    = valid_q;
    if (load1) begin
      valid_d[0] = in_valid;
    end
    if (advance2) begin
      valid_d[1] = valid_q[0];
    end
  end

  // Decode the double fields into single-precision rebiased exponent,
  // truncated mantissa, guard/sticky and special-value classes.
  always_comb begin
    conv_d    = (op_type[2] & op_type[1]) ^ P[0];
    expField  = result_dp[62:52];
    fracField = result_dp[51:0];
    es_d      = {1'b0, expField} - 12'd896;
    nan_d     = (expField == 11'h7FF) && (fracField != 52'd0);
    inf_d     = (expField == 11'h7FF) && (fracField == 52'd0);
    zero_d    = (expField == 11'h000) && (fracField == 52'd0);
    tiny_d    = (expField != 11'h7FF) && (es_d <= 12'sd0) && !zero_d;
  end

  // Round the mantissa by the selected mode, detect overflow and assemble
  // the final packed result and exception flags.
  always_comb begin
    sign = s1Dp_q[63];
    case (s1Rm_q)
      2'b00:   inc = s1Guard_q & (s1Sticky_q | s1Man_q[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = ~sign & (s1Guard_q | s1Sticky_q);
      default: inc = sign & (s1Guard_q | s1Sticky_q);
    endcase
    {carry, manRnd} = {1'b0, s1Man_q} + {23'd0, inc};
    esRnd    = s1Es_q + {11'd0, carry};
    overflow = esRnd >= 12'sd255;
    toInf    = (s1Rm_q == 2'b00) || ((s1Rm_q == 2'b10) && !sign) ||
               ((s1Rm_q == 2'b11) && sign);
    result_d = 64'd0;
    of_d     = 1'b0;
    uf_d     = 1'b0;
    nx_d     = 1'b0;
    if (!s1Conv_q) begin
      result_d = s1Dp_q;
    end else if (s1Nan_q) begin
      result_d = {QNAN_SP, 32'd0};
    end else if (s1Inf_q) begin
      result_d = {sign, 8'hFF, 23'd0, 32'd0};
    end else if (s1Zero_q) begin
      result_d = {sign, 63'd0};
    end else if (s1Tiny_q) begin
      result_d = {sign, 63'd0};
      uf_d     = 1'b1;
      nx_d     = 1'b1;
    end else if (overflow) begin
      of_d     = 1'b1;
      nx_d     = 1'b1;
      result_d = toInf ? {sign, 8'hFF, 23'd0, 32'd0}
                       : {sign, 8'hFE, 23'h7FFFFF, 32'd0};
    end else begin
      result_d = {sign, esRnd[7:0], manRnd, 32'd0};
      nx_d     = s1Guard_q | s1Sticky_q;
    end
  end

  // Stage occupancy; reset empties the pipe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Stage 1 captures the decoded fields on an accepted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Conv_q   <= 1'b0;
      s1Dp_q     <= 64'd0;
      s1Es_q     <= 12'sd0;
      s1Man_q    <= 23'd0;
      s1Guard_q  <= 1'b0;
      s1Sticky_q <= 1'b0;
      s1Nan_q    <= 1'b0;
      s1Inf_q    <= 1'b0;
      s1Zero_q   <= 1'b0;
      s1Tiny_q   <= 1'b0;
      s1Rm_q     <= 2'b00;
    end else if (load1 && in_valid) begin
      s1Conv_q   <= conv_d;
      s1Dp_q     <= result_dp;
      s1Es_q     <= es_d;
      s1Man_q    <= fracField[51:29];
      s1Guard_q  <= fracField[28];
      s1Sticky_q <= |fracField[27:0];
      s1Nan_q    <= nan_d;
      s1Inf_q    <= inf_d;
      s1Zero_q   <= zero_d;
      s1Tiny_q   <= tiny_d;
      s1Rm_q     <= rm;
    end
  end

  // Stage 2 registers the packed result; it holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= 64'd0;
      of_q     <= 1'b0;
      uf_q     <= 1'b0;
      nx_q     <= 1'b0;
    end else if (advance2 && valid_q[0]) begin
      result_q <= result_d;
      of_q     <= of_d;
      uf_q     <= uf_d;
      nx_q     <= nx_d;
    end
  end

  assign out_valid = valid_q[1];
  assign result    = result_q;
  assign flag_of   = of_q;
  assign flag_uf   = uf_q;
  assign flag_nx   = nx_q;

endmodule

// File: tb/tb_convert_outputs.sv
// tb_convert_outputs: directed and randomized checks of convert_outputs
// against a numeric reference model and an in-order scoreboard.
module tb_convert_outputs;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] result_dp;
  logic [2:0]  op_type;
  logic [1:0]  P;
  logic [1:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        flag_of;
  logic        flag_uf;
  logic        flag_nx;

  int checks;
  int errors;
  int outCount;
  logic [66:0] expQ[$];

  convert_outputs dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result_dp (result_dp),
    .op_type   (op_type),
    .P         (P),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_of   (flag_of),
    .flag_uf   (flag_uf),
    .flag_nx   (flag_nx)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Numeric reference: returns {of, uf, nx, result64}.
  function automatic logic [66:0] refConv(input logic [63:0] dp, input logic [2:0] op,
                                          input logic [1:0] p, input logic [1:0] r);
    logic s;
    int e;
    int es;
    longint sig;
    longint rem;
    longint half;
    logic [51:0] f;
    logic up;
    logic [31:0] sp;
    logic ofv, ufv, nxv;
    if (((op[2] & op[1]) ^ p[0]) == 1'b0) return {3'b000, dp};
    s = dp[63];
    e = int'(dp[62:52]);
    f = dp[51:0];
    ofv = 1'b0; ufv = 1'b0; nxv = 1'b0;
    if (e == 2047) begin
      sp = (f != 52'd0) ? 32'h7FC00000 : {s, 8'hFF, 23'd0};
    end else if (e == 0 && f == 52'd0) begin
      sp = {s, 31'd0};
    end else begin
      es = e - 896;
      if (es <= 0) begin
        sp = {s, 31'd0};
        ufv = 1'b1;
        nxv = 1'b1;
      end else begin
        sig  = longint'(f[51:29]) + (longint'(1) << 23);
        rem  = longint'(f[28:0]);
        half = longint'(1) << 28;
        case (r)
          2'b00:   up = (rem > half) || (rem == half && (sig % 2) == 1);
          2'b01:   up = 1'b0;
          2'b10:   up = !s && rem != 0;
          default: up = s && rem != 0;
        endcase
        if (up) sig = sig + 1;
        if (sig == (longint'(1) << 24)) begin
          sig = longint'(1) << 23;
          es = es + 1;
        end
        nxv = (rem != 0);
        if (es >= 255) begin
          ofv = 1'b1;
          nxv = 1'b1;
          if (r == 2'b00 || (r == 2'b10 && !s) || (r == 2'b11 && s))
            sp = {s, 8'hFF, 23'd0};
          else
            sp = {s, 8'hFE, 23'h7FFFFF};
        end else begin
          sp = {s, 8'(es), 23'(sig)};
        end
      end
    end
    return {ofv, ufv, nxv, sp, 32'd0};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One cycle: drive at the falling edge, then sample both handshakes.
  task automatic applyStimulus(input bit v, input logic [63:0] dp, input logic [2:0] op,
                               input logic [1:0] p, input logic [1:0] r, input bit ordy,
                               output bit accepted);
    logic [66:0] e;
    @(negedge clk);
    in_valid  = v;
    result_dp = dp;
    op_type   = op;
    P         = p;
    rm        = r;
    out_ready = ordy;
    #1;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      outCount++;
      if (expQ.size() == 0) begin
        checkOutput("spuriousOut", {63'd0, out_valid}, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("result", result, e[63:0]);
        checkOutput("flags", {61'd0, flag_of, flag_uf, flag_nx}, {61'd0, e[66:64]});
      end
    end
    if (accepted) expQ.push_back(refConv(dp, op, p, r));
  endtask

  task automatic drain(input string tag);
    bit acc;
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      applyStimulus(1'b0, 64'd0, 3'b000, 2'b01, 2'b00, 1'b1, acc);
      n++;
    end
    checkOutput(tag, 64'(expQ.size()), 64'd0);
    expQ.delete();
  endtask

  function automatic logic [63:0] randDp();
    logic [63:0] d;
    logic [10:0] e;
    d = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: e = d[62:52];
      1: e = 11'(1145 + $urandom_range(0, 6));
      2: e = 11'(888 + $urandom_range(0, 12));
      3: begin
        e = ($urandom_range(0, 1) == 0) ? 11'h7FF : 11'h000;
        if ($urandom_range(0, 1) == 0) d[51:0] = 52'd0;
      end
      4: begin
        e = 11'(897 + $urandom_range(0, 253));
        d[51:29] = 23'h7FFFFF;
      end
      5: begin
        e = 11'(897 + $urandom_range(0, 253));
        d[28:0] = 29'h10000000;
      end
      default: e = 11'(897 + $urandom_range(0, 253));
    endcase
    d[62:52] = e;
    return d;
  endfunction

  logic [63:0] plan[8];
  logic [1:0]  planRm[8];
  logic [63:0] bp[4];
  logic [63:0] held;

  initial begin
    bit acc;
    int idx;
    int startCount;
    int n;
    checks = 0;
    errors = 0;
    outCount = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    result_dp = 64'd0;
    op_type = 3'b000;
    P = 2'b01;
    rm = 2'b00;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstOutValid", {63'd0, out_valid}, 64'd0);
    checkOutput("rstResult", result, 64'd0);
    checkOutput("rstFlags", {61'd0, flag_of, flag_uf, flag_nx}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rstInReady", {63'd0, in_ready}, 64'd1);

    // Latency of a single transfer
    applyStimulus(1'b1, 64'h3FF0000000000000, 3'b000, 2'b01, 2'b00, 1'b1, acc);
    checkOutput("latAccept", {63'd0, acc}, 64'd1);
    applyStimulus(1'b0, 64'd0, 3'b000, 2'b01, 2'b00, 1'b1, acc);
    checkOutput("latCycle1", {63'd0, out_valid}, 64'd0);
    applyStimulus(1'b0, 64'd0, 3'b000, 2'b01, 2'b00, 1'b1, acc);
    checkOutput("latCycle2", {63'd0, out_valid}, 64'd1);
    checkOutput("latValue", result, 64'h3F80000000000000);

    // Directed conversion cases
    plan[0] = 64'h3FF0000010000000; planRm[0] = 2'b00;
    plan[1] = 64'h3FF0000030000000; planRm[1] = 2'b00;
    plan[2] = 64'h47F0000000000000; planRm[2] = 2'b00;
    plan[3] = 64'h47F0000000000000; planRm[3] = 2'b01;
    plan[4] = 64'hC7F0000000000000; planRm[4] = 2'b10;
    plan[5] = 64'h3800000000000000; planRm[5] = 2'b00;
    plan[6] = 64'h7FF8000000000000; planRm[6] = 2'b00;
    plan[7] = 64'hFFF0000000000000; planRm[7] = 2'b00;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, plan[i], 3'b000, 2'b01, planRm[i], 1'b1, acc);
      drain("planDrain");
    end
    applyStimulus(1'b1, 64'h0123456789ABCDEF, 3'b000, 2'b00, 2'b00, 1'b1, acc);
    drain("passDrain");

    // Backpressure: two accepted, then stall with stable output
    bp[0] = 64'h3FF0000000000000;
    bp[1] = 64'h4000000030000000;
    bp[2] = 64'hBFF8000000000000;
    bp[3] = 64'h0123456789ABCDEF;
    idx = 0;
    startCount = outCount;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, bp[idx], 3'b000, (idx == 3) ? 2'b00 : 2'b01, 2'b00, 1'b0, acc);
      if (acc) idx++;
      if (c == 2) begin
        checkOutput("bpInReady", {63'd0, in_ready}, 64'd0);
        checkOutput("bpAccepted", 64'(idx), 64'd2);
        checkOutput("bpOutValid", {63'd0, out_valid}, 64'd1);
        held = result;
      end
      if (c == 3) begin
        checkOutput("bpHold", result, held);
        checkOutput("bpHoldValid", {63'd0, out_valid}, 64'd1);
      end
    end
    n = 0;
    while (outCount - startCount < 4 && n < 20) begin
      if (idx < 4) begin
        applyStimulus(1'b1, bp[idx], 3'b000, (idx == 3) ? 2'b00 : 2'b01, 2'b00, 1'b1, acc);
        if (acc) idx++;
      end else begin
        applyStimulus(1'b0, 64'd0, 3'b000, 2'b01, 2'b00, 1'b1, acc);
      end
      n++;
    end
    checkOutput("bpCount", 64'(outCount - startCount), 64'd4);
    drain("bpDrain");

    // Reset with two results in flight
    applyStimulus(1'b1, 64'h3FF0000000000000, 3'b000, 2'b01, 2'b00, 1'b0, acc);
    applyStimulus(1'b1, 64'h4000000000000000, 3'b000, 2'b01, 2'b00, 1'b0, acc);
    #2;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("midRstOutValid", {63'd0, out_valid}, 64'd0);
    expQ.delete();
    @(negedge clk);
    reset = 1'b0;
    startCount = outCount;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 64'd0, 3'b000, 2'b01, 2'b00, 1'b1, acc);
    end
    checkOutput("postRstEmits", 64'(outCount - startCount), 64'd0);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, randDp(), 3'($urandom), 2'($urandom),
                    2'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    drain("randDrain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
